enc_quad_decoder: RTL and testbench
===================================

Name: enc_quad_decoder

Overview:
- Front-end for each encoder channel. Takes raw quadrature A/B inputs and synchronizes them into clk_fast. Each channel has a digital glitch filter.
- Decodes x4 quadrature into a signed position count.
- Emits a one-cycle tick pulse and a direction bit per valid transition. These drive the downstream encoder-period stage's ticks/dir inputs and the position readback register.

Parameters:
- FILT_LEN, 3, consecutive identical samples needed before a filtered channel changes; legal range 1..15.
- POS_W, 24, position counter width in bits.

Ports:
- clk_fast, input, 1, fast sampling clock; all logic is on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- enc_a, input, 1, raw encoder channel A (asynchronous).
- enc_b, input, 1, raw encoder channel B (asynchronous).
- preload_en, input, 1, synchronous position load strobe.
- preload_val, input, POS_W, value loaded into pos.
- clr_err, input, 1, clears the sticky error flag.
- pos, output, POS_W, two's-complement position count.
- ticks, output, 1, one-cycle pulse per valid quadrature transition.
- dir, output, 1, direction of the last valid transition; 1 = forward.
- err, output, 1, sticky illegal-transition flag.
- a_filt, output, 1, filtered channel A state.
- b_filt, output, 1, filtered channel B state.

Behaviour:
- Reset (reset=0, asynchronous):
  - pos=0, ticks=0, dir=1, err=0, a_filt=0, b_filt=0.
  - Synchronizer flops, filter counters and decoder state are cleared.
  - Startup counter is cleared.
- Synchronizer: two flops per channel. A raw change captured at edge k appears at the sync output after edge k+1.
- Filter, per channel:
  - 4-bit counter. It clears whenever the sync value equals the filtered value, and increments while they differ.
  - The filtered value takes the sync value on the edge where the counter would reach FILT_LEN; the counter then clears.
  - A pulse shorter than FILT_LEN consecutive samples never reaches a_filt/b_filt.
- Decoder:
  - Registers the previous filtered state {a,b} and compares it with the current {a_filt,b_filt} each cycle.
  - Forward sequence is 00→10→11→01→00 (A leads B): pos+1, dir=1, ticks=1.
  - Reverse sequence is 00→01→11→10→00: pos-1, dir=0, ticks=1.
  - No change: ticks=0; pos and dir hold.
  - Both bits change in the same cycle (illegal): err=1, no count, no tick, dir holds. The previous state is updated to the new value, so decoding resumes cleanly.
- Latency:
  - A clean raw edge captured at edge k gives a_filt/b_filt updated at edge k+FILT_LEN+1.
  - ticks/pos/dir are updated at edge k+FILT_LEN+2.
  - ticks is high for exactly one clk_fast cycle.
- Startup window:
  - Lasts FILT_LEN+3 cycles after reset deasserts.
  - During the window, a_filt/b_filt and the previous-state register load the sync outputs directly every cycle.
  - ticks is forced 0, pos does not change, and err cannot set.
  - This prevents a spurious tick or error when the encoder rests at 11 or 01.
- pos arithmetic: modulo 2^POS_W. 0 − 1 → all ones; max + 1 → 0. No saturation, no overflow flag.
- Preload:
  - preload_en=1 loads pos=preload_val on that edge and has priority over a same-cycle count, which is discarded.
  - ticks and dir still update normally for that transition.
- err:
  - Sticky; cleared by clr_err=1 on an edge.
  - An illegal transition in the same cycle as clr_err leaves err=1 (set wins).
- Reset mid-operation: everything returns to reset values immediately, and a new startup window runs after deassertion.
- Consecutive transitions closer than FILT_LEN+1 cycles are not guaranteed to be counted. The minimum encoder edge spacing the block supports is FILT_LEN+1 clk_fast cycles.

Test Plan:
1. Forward motion, FILT_LEN=3: after the startup window, drive 8 forward edges 10 cycles apart. Expect pos 0→8, dir=1, exactly 8 one-cycle ticks. Each tick occurs 5 cycles after the capturing edge.
2. Reverse from pos=0: drive 3 reverse edges. Expect pos=0xFFFFFD (24-bit), dir=0, 3 ticks, err=0.
3. Glitch rejection: a 2-cycle pulse on enc_a with FILT_LEN=3. Expect a_filt unchanged, no tick, pos unchanged. A 3-cycle pulse is accepted: expect two ticks, net pos 0.
4. Illegal transition: drive AB from 00 to 11 in one cycle. Expect err=1, no tick, pos unchanged. A following legal 11→01 transition gives pos+1. Assert clr_err with no illegal event: expect err=0.
5. Preload and wrap:
   - preload_val=0xFFFFFF, then one forward edge: expect pos=0x000000.
   - preload_en in the same cycle as a reverse transition: expect pos=preload_val, dir=0, one tick.
6. Startup and reset: hold AB=11 through reset release. Expect a_filt=b_filt=1 by the end of the window with no tick and err=0. Assert reset mid-motion: expect pos=0 and dir=1 immediately.

Source files
------------

// File: rtl/enc_quad_decoder.sv
// Quadrature front-end: 2-flop sync, per-channel glitch filter and x4 decode into a signed position.
// Raw edge to ticks/pos is FILT_LEN+3 clk_fast edges; no backpressure, ticks is a one-cycle pulse.
module enc_quad_decoder #(
  parameter int FILT_LEN = 3,
  parameter int POS_W    = 24
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             preload_en,
  input  logic [POS_W-1:0] preload_val,
  input  logic             clr_err,
  output logic [POS_W-1:0] pos,
  output logic             ticks,
  output logic             dir,
  output logic             err,
  output logic             a_filt,
  output logic             b_filt
);

  localparam logic [3:0]       LP_FILT_LEN   = 4'(FILT_LEN);
  localparam logic [4:0]       LP_START_LAST = 5'(FILT_LEN + 2);
  localparam logic [POS_W-1:0] LP_POS_ONE    = POS_W'(1);

  typedef enum logic [0:0] {
    ST_START,
    ST_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_start_cnt;
  logic [4:0]       w_start_cnt_nxt;
  logic             w_window;

  // Channel vectors are {A, B}: bit 1 is A, bit 0 is B.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [3:0]       r_fcnt [2];
  logic [3:0]       w_fcnt_inc [2];
  logic [1:0]       r_filt;
  logic [1:0]       r_prev;

  logic [1:0]       w_delta;
  logic             w_step;
  logic             w_illegal;
  logic             w_fwd;

  logic [POS_W-1:0] r_pos;
  logic             r_ticks;
  logic             r_dir;
  logic             r_err;

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {enc_a, enc_b};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_START;
      r_start_cnt <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_cnt <= w_start_cnt_nxt;
    end
  end

  // Startup window: filter and decoder track the sync outputs until the sync chain is settled.
  always_comb begin
    w_state_nxt     = r_state;
    w_start_cnt_nxt = r_start_cnt;
    w_window        = 1'b0;
    case (r_state)
      ST_START: begin
        w_window        = 1'b1;
        w_start_cnt_nxt = r_start_cnt + 5'd1;
        if (r_start_cnt == LP_START_LAST) begin
          w_state_nxt     = ST_RUN;
          w_start_cnt_nxt = 5'd0;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt     = ST_START;
        w_start_cnt_nxt = 5'd0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_fcnt_inc[i] = r_fcnt[i] + 4'd1;
    end
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      r_fcnt[0] <= 4'd0;
      r_fcnt[1] <= 4'd0;
      r_filt    <= 2'b00;
    end else if (w_window) begin
      r_fcnt[0] <= 4'd0;
      r_fcnt[1] <= 4'd0;
      r_filt    <= r_sync2;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= 4'd0;
        end else if (w_fcnt_inc[i] == LP_FILT_LEN) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= 4'd0;
        end else begin
          r_fcnt[i] <= w_fcnt_inc[i];
        end
      end
    end
  end

  // Forward (A leads B) exactly when the previous B differs from the new A.
  always_comb begin
    w_delta   = r_prev ^ r_filt;
    w_step    = (w_delta == 2'b01) || (w_delta == 2'b10);
    w_illegal = (w_delta == 2'b11);
    w_fwd     = r_prev[0] ^ r_filt[1];
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      r_prev  <= 2'b00;
      r_pos   <= '0;
      r_ticks <= 1'b0;
      r_dir   <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_ticks <= 1'b0;
      r_prev  <= w_window ? r_sync2 : r_filt;

      if (!w_window && w_step) begin
        r_ticks <= 1'b1;
        r_dir   <= w_fwd;
      end

      if (preload_en) begin
        r_pos <= preload_val;
      end else if (!w_window && w_step) begin
        r_pos <= w_fwd ? (r_pos + LP_POS_ONE) : (r_pos - LP_POS_ONE);
      end

      if (!w_window && w_illegal) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign pos    = r_pos;
  assign ticks  = r_ticks;
  assign dir    = r_dir;
  assign err    = r_err;
  assign a_filt = r_filt[1];
  assign b_filt = r_filt[0];

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Scoreboard bench for enc_quad_decoder: expected ticks are queued at drive time and matched when ticks fires.
module tb_enc_quad_decoder;
  localparam int FILT_LEN = 3;
  localparam int POS_W    = 24;
  localparam int LAT      = FILT_LEN + 3;

  logic             clk_fast = 1'b0;
  logic             reset;
  logic             enc_a;
  logic             enc_b;
  logic             preload_en;
  logic [POS_W-1:0] preload_val;
  logic             clr_err;
  logic [POS_W-1:0] pos;
  logic             ticks;
  logic             dir;
  logic             err;
  logic             a_filt;
  logic             b_filt;

  always #5 clk_fast = ~clk_fast;

  enc_quad_decoder #(.FILT_LEN(FILT_LEN), .POS_W(POS_W)) dut (
    .clk_fast    (clk_fast),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .preload_en  (preload_en),
    .preload_val (preload_val),
    .clr_err     (clr_err),
    .pos         (pos),
    .ticks       (ticks),
    .dir         (dir),
    .err         (err),
    .a_filt      (a_filt),
    .b_filt      (b_filt)
  );

  typedef struct {
    int               cyc;
    logic [POS_W-1:0] pos;
    logic             dir;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               cyc      = 0;
  int               n_chk    = 0;
  int               n_fail   = 0;
  int               n_ticks  = 0;
  int               n_pushed = 0;
  int               base;
  logic [POS_W-1:0] m_pos;
  logic             m_dir;
  logic [1:0]       m_ab;
  logic [1:0]       fwd_nxt [4];
  logic [1:0]       fseq [4];
  logic [1:0]       rseq [3];
  logic             a_seen;

  always @(posedge clk_fast) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_fast);
  endtask

  // Model keyed on {A,B}: a step is forward when the new state is the forward successor.
  task automatic drive_ab(input logic [1:0] ab, input bit pre, input logic [POS_W-1:0] pv, input int gap);
    exp_t e;
    bit   legal;
    legal = 1'b0;
    if (fwd_nxt[m_ab] == ab) begin
      m_pos = m_pos + 24'd1;
      m_dir = 1'b1;
      legal = 1'b1;
    end else if (fwd_nxt[ab] == m_ab) begin
      m_pos = m_pos - 24'd1;
      m_dir = 1'b0;
      legal = 1'b1;
    end
    if (pre) m_pos = pv;
    m_ab = ab;
    {enc_a, enc_b} = ab;
    if (legal) begin
      e.cyc = cyc + LAT;
      e.pos = m_pos;
      e.dir = m_dir;
      sb_q.push_back(e);
      n_pushed++;
    end
    if (pre) begin
      idle(LAT - 1);
      preload_val = pv;
      preload_en  = 1'b1;
      idle(1);
      preload_en  = 1'b0;
      idle(gap - LAT);
    end else begin
      idle(gap);
    end
  endtask

  task automatic preload_only(input logic [POS_W-1:0] pv);
    preload_val = pv;
    preload_en  = 1'b1;
    idle(1);
    preload_en  = 1'b0;
    m_pos       = pv;
    idle(2);
  endtask

  always @(negedge clk_fast) begin
    if (ticks === 1'b1) begin
      n_ticks++;
      if (sb_q.size() == 0) begin
        chk("tick_unexpected", 32'(ticks), 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("tick_cyc", cyc, mon_e.cyc);
        chk("tick_pos", 32'(pos), 32'(mon_e.pos));
        chk("tick_dir", 32'(dir), 32'(mon_e.dir));
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      mon_e = sb_q.pop_front();
      chk("tick_missing", cyc, mon_e.cyc);
    end
  end

  initial begin
    fwd_nxt[0] = 2'b10;
    fwd_nxt[2] = 2'b11;
    fwd_nxt[3] = 2'b01;
    fwd_nxt[1] = 2'b00;
    fseq[0] = 2'b10; fseq[1] = 2'b11; fseq[2] = 2'b01; fseq[3] = 2'b00;
    rseq[0] = 2'b01; rseq[1] = 2'b11; rseq[2] = 2'b10;
    reset = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
    preload_en = 1'b0; preload_val = '0; clr_err = 1'b0;
    m_pos = '0; m_dir = 1'b1; m_ab = 2'b00;

    idle(3);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_ticks", 32'(ticks), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_afilt", 32'(a_filt), 0);
    chk("rst_bfilt", 32'(b_filt), 0);
    reset = 1'b1;
    idle(FILT_LEN + 6);

    // Forward motion
    base = n_ticks;
    for (int i = 0; i < 8; i++) drive_ab(fseq[i % 4], 1'b0, '0, 10);
    chk("fwd_pos", 32'(pos), 8);
    chk("fwd_dir", 32'(dir), 1);
    chk("fwd_ticks", n_ticks - base, 8);

    // Reverse through zero
    preload_only('0);
    chk("preload_zero", 32'(pos), 0);
    base = n_ticks;
    for (int i = 0; i < 3; i++) drive_ab(rseq[i], 1'b0, '0, 10);
    chk("rev_pos", 32'(pos), 'hFFFFFD);
    chk("rev_dir", 32'(dir), 0);
    chk("rev_ticks", n_ticks - base, 3);
    chk("rev_err", 32'(err), 0);

    // Glitch rejection then acceptance
    drive_ab(2'b00, 1'b0, '0, 10);
    base   = n_ticks;
    a_seen = 1'b0;
    enc_a  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_fast);
      a_seen = a_seen | a_filt;
      if (i == 1) enc_a = 1'b0;
    end
    chk("glitch_afilt", 32'(a_seen), 0);
    chk("glitch_ticks", n_ticks - base, 0);
    chk("glitch_pos", 32'(pos), 'hFFFFFC);
    drive_ab(2'b10, 1'b0, '0, 3);
    drive_ab(2'b00, 1'b0, '0, 12);
    chk("accept_ticks", n_ticks - base, 2);
    chk("accept_pos", 32'(pos), 'hFFFFFC);

    // Illegal transition, recovery, clear, set-wins
    base = n_ticks;
    drive_ab(2'b11, 1'b0, '0, 10);
    chk("ill_err", 32'(err), 1);
    chk("ill_pos", 32'(pos), 'hFFFFFC);
    chk("ill_ticks", n_ticks - base, 0);
    drive_ab(2'b01, 1'b0, '0, 10);
    chk("ill_resume_pos", 32'(pos), 'hFFFFFD);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    chk("clr_err", 32'(err), 0);
    drive_ab(2'b10, 1'b0, '0, LAT - 1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(8);
    chk("setwins_err", 32'(err), 1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    chk("clr_err2", 32'(err), 0);

    // Preload and wrap
    preload_only(24'hFFFFFF);
    chk("preload_max", 32'(pos), 'hFFFFFF);
    drive_ab(2'b11, 1'b0, '0, 10);
    chk("wrap_pos", 32'(pos), 0);
    drive_ab(2'b10, 1'b1, 24'h123456, 12);
    chk("pre_rev_pos", 32'(pos), 'h123456);
    chk("pre_rev_dir", 32'(dir), 0);

    // Reset mid-motion, then startup resting at 11
    drive_ab(2'b00, 1'b0, '0, 10);
    {enc_a, enc_b} = 2'b11;
    idle(3);
    #1 reset = 1'b0;
    #1;
    chk("midrst_pos", 32'(pos), 0);
    chk("midrst_dir", 32'(dir), 1);
    chk("midrst_afilt", 32'(a_filt), 0);
    m_pos = '0; m_dir = 1'b1; m_ab = 2'b11;
    idle(4);
    reset = 1'b1;
    base  = n_ticks;
    idle(FILT_LEN + 3);
    chk("su_afilt", 32'(a_filt), 1);
    chk("su_bfilt", 32'(b_filt), 1);
    chk("su_err", 32'(err), 0);
    idle(10);
    chk("su_ticks", n_ticks - base, 0);
    chk("su_pos", 32'(pos), 0);
    drive_ab(2'b01, 1'b0, '0, 10);
    chk("su_resume_pos", 32'(pos), 1);

    chk("sb_drained", sb_q.size(), 0);
    chk("tick_total", n_ticks, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
